// File: rtl/sdmips_pkg.sv
// Shared SDMips datapath definitions: PC width/step, PC type and the 4-bit
// carry-lookahead group helper used by the datapath adders.
package sdmips_pkg;

    localparam int unsigned PC_WIDTH  = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam int unsigned CLA_GROUP = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

    // Lookahead result of one 4-bit group: group generate/propagate and the
    // carry into each bit of the group.
    typedef struct packed {
        logic       gg;
        logic       gp;
        logic [3:0] carry;
    } cla4_t;

    function automatic cla4_t cla4(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       cin
    );
        cla4_t r;
        r.carry[0] = cin;
        r.carry[1] = g[0] | (p[0] & cin);
        r.carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);
        r.gp       = &p;
        r.gg       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/somador_cla.sv
// Parameterised carry-lookahead adder built from 4-bit lookahead groups,
// with group carries chained through each group's generate/propagate.
module somador_cla
    import sdmips_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NGROUPS = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;
    localparam int unsigned PW      = NGROUPS * CLA_GROUP;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] p;
    logic [PW-1:0] g;
    logic [PW:0]   c;
    logic [PW-1:0] sum_ext;
    logic          grp_cy;
    cla4_t         grp;

    // Operands padded to a whole number of groups; padded bits neither
    // generate nor propagate, so the carry into bit WIDTH is the true carry-out.
    always_comb begin
        a_ext = PW'(a);
        b_ext = PW'(b);
        p     = a_ext ^ b_ext;
        g     = a_ext & b_ext;
        c     = '0;
        grp   = '0;
        grp_cy = cin;
        for (int unsigned k = 0; k < NGROUPS; k++) begin
            grp = cla4(p[CLA_GROUP*k +: CLA_GROUP], g[CLA_GROUP*k +: CLA_GROUP], grp_cy);
            c[CLA_GROUP*k +: CLA_GROUP] = grp.carry;
            grp_cy = grp.gg | (grp.gp & grp_cy);
        end
        c[PW]   = grp_cy;
        sum_ext = p ^ c[PW-1:0];
    end

    assign sum  = sum_ext[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/somador_pc_core.sv
// Sequential next-PC: combinational PC + step with carry-out, plus an
// enable-loaded registered copy for pipeline/debug use.
module somador_pc_core
    import sdmips_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH,
    parameter int unsigned INCREMENT = PC_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_1,
    input  logic             en,
    output logic [WIDTH-1:0] resul_soma,
    output logic             wrap,
    output logic [WIDTH-1:0] resul_soma_q,
    output logic             wrap_q
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    // Same-cycle sum for fetch; deliberately not reset.
    somador_cla #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (op_1),
        .b    (STEP),
        .cin  (1'b0),
        .sum  (resul_soma),
        .cout (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resul_soma_q <= '0;
            wrap_q       <= 1'b0;
        end else if (en) begin
            resul_soma_q <= resul_soma;
            wrap_q       <= wrap;
        end
    end

endmodule

// File: tb/tb_somador_pc_core.sv
// Self-checking bench for somador_pc_core: directed corners, reset behaviour
// and randomized PCs against an arithmetic reference model.
module tb_somador_pc_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] op_1;
    logic        en;
    logic [31:0] resul_soma;
    logic        wrap;
    logic [31:0] resul_soma_q;
    logic        wrap_q;

    int unsigned n_vec;
    int unsigned n_err;

    logic [31:0] exp_q;
    logic        exp_wrap_q;
    logic [32:0] ref_sum;

    somador_pc_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_1         (op_1),
        .en           (en),
        .resul_soma   (resul_soma),
        .wrap         (wrap),
        .resul_soma_q (resul_soma_q),
        .wrap_q       (wrap_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(input logic [31:0] pc);
        return 33'(pc) + 33'd4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag, input logic [31:0] pc);
        logic [32:0] s;
        s = ref_add(pc);
        check({tag, "_sum"}, 64'(resul_soma), 64'(s[31:0]));
        check({tag, "_wrap"}, 64'(wrap), 64'(s[32]));
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        op_1   = 32'h0;
        #1;
        check("reset_q", 64'(resul_soma_q), 64'h0);
        check("reset_wrap_q", 64'(wrap_q), 64'h0);

        // Small values, unaligned included.
        for (int i = 0; i < 5; i++) begin
            op_1 = 32'(i);
            #1;
            check("small_sum", 64'(resul_soma), 64'(i + 4));
            check("small_wrap", 64'(wrap), 64'h0);
        end

        op_1 = 32'hFFFF_FFFC;
        #1;
        check("wrap_fffc_sum", 64'(resul_soma), 64'h0);
        check("wrap_fffc_wrap", 64'(wrap), 64'h1);
        op_1 = 32'hFFFF_FFFF;
        #1;
        check("wrap_ffff_sum", 64'(resul_soma), 64'h3);
        check("wrap_ffff_wrap", 64'(wrap), 64'h1);

        // Clocks under reset must not load.
        op_1 = 32'h0040_0000;
        en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_sum", 64'(resul_soma), 64'h0040_0004);
        check("rst_hold_q", 64'(resul_soma_q), 64'h0);
        check("rst_hold_wrap_q", 64'(wrap_q), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        op_1  = 32'h0040_0000;
        @(posedge clk);
        #1;
        check("load_q", 64'(resul_soma_q), 64'h0040_0004);
        check("load_wrap_q", 64'(wrap_q), 64'h0);

        @(negedge clk);
        op_1 = 32'h0040_0004;
        en   = 1'b0;
        @(posedge clk);
        #1;
        check("hold_q", 64'(resul_soma_q), 64'h0040_0004);
        check("hold_comb", 64'(resul_soma), 64'h0040_0008);

        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("load2_q", 64'(resul_soma_q), 64'h0040_0008);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", 64'(resul_soma_q), 64'h0);
        check("async_rst_wrap_q", 64'(wrap_q), 64'h0);
        check("async_rst_comb", 64'(resul_soma), 64'h0040_0008);

        // Registered wrap flag.
        @(negedge clk);
        rst_n = 1'b1;
        op_1  = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        check("wrap_q_set", 64'(wrap_q), 64'h1);
        check("wrap_q_sum", 64'(resul_soma_q), 64'h2);

        exp_q      = 32'h2;
        exp_wrap_q = 1'b1;

        // Random PCs with random enables, biased toward the top of memory.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                op_1 = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                op_1 = $urandom;
            en = 1'($urandom_range(0, 3) != 0);
            #1;
            check_comb("rand", op_1);
            @(posedge clk);
            if (en) begin
                ref_sum    = ref_add(op_1);
                exp_q      = ref_sum[31:0];
                exp_wrap_q = ref_sum[32];
            end
            #1;
            check("rand_q", 64'(resul_soma_q), 64'(exp_q));
            check("rand_wrap_q", 64'(wrap_q), 64'(exp_wrap_q));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/somador_pc_core.md
# somador_pc_core

PC incrementer for the SDMips datapath: adds a fixed step to the current program counter and returns the sequential next-PC. The sum output is purely combinational so the fetch stage can use it in the same cycle. A clocked copy of the sum and a wrap flag are also provided for pipeline and debug use. It sits between the PC register and the next-PC multiplexer.

## Interface
- `WIDTH`, 32, address width in bits.
- `INCREMENT`, 4, constant step added to the PC, in bytes. Must be less than 2**WIDTH.

- `clk`  input  1  single clock; all registers sample on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `op_1`  input  WIDTH  current PC value.
- `en`  input  1  load enable for the registered outputs.
- `resul_soma`  output  WIDTH  combinational result, op_1 + INCREMENT, modulo 2**WIDTH.
- `wrap`  output  1  combinational carry-out of the addition; 1 when the sum overflows WIDTH bits.
- `resul_soma_q`  output  WIDTH  registered copy of resul_soma.
- `wrap_q`  output  1  registered copy of wrap.

## Operation
- Computes resul_soma = (op_1 + INCREMENT) mod 2**WIDTH. The sum is unsigned.
- `wrap` is the carry-out bit WIDTH of the full-width sum.
- There is no saturation. For example, 0xFFFF_FFFC + 4 gives 0x0000_0000 with wrap = 1.
- Alignment of op_1 is not checked. Odd values are added as given, for example 1 gives 5.
- On a rising edge of clk with en = 1:
  - resul_soma_q takes resul_soma.
  - wrap_q takes wrap.
- With en = 0, resul_soma_q and wrap_q hold their values.
- rst_n = 0 has these effects:
  - resul_soma_q and wrap_q clear to 0 immediately, without waiting for a clock edge.
  - They stay at 0 while rst_n is low.
- Reset has no effect on the combinational outputs. resul_soma and wrap always track op_1, even during reset.
- Reset release is synchronous in effect: the first load happens on the first rising edge after rst_n goes high with en = 1.

## Timing
- Combinational path op_1 → resul_soma/wrap has zero cycles of latency.
  - Outputs must settle within 0.1 ns of simulated time after an op_1 change.
  - No delays are modelled in the RTL.
- Registered path has 1 cycle of latency: the value present before edge k appears on resul_soma_q after edge k.
- Reset values:
  - resul_soma_q = 0, wrap_q = 0.
  - resul_soma and wrap: no reset value, since they follow op_1.
- If reset is asserted at the same time as a clock edge, reset wins and the outputs are 0.
- Changes to op_1 between clock edges affect only the combinational outputs.

## Structure
- Shared package `sdmips_pkg` holds:
  - the constants `PC_WIDTH = 32` and `PC_STEP = 4`;
  - the typedef `pc_t` (logic [PC_WIDTH-1:0]), which the PC register, branch adder and jump logic also use.
- Sub-module `somador_cla`:
  - a parameterised WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups;
  - inputs a, b, cin; outputs sum, cout;
  - `somador_pc_core` instantiates it with b = INCREMENT and cin = 0.
- The output register lives in `somador_pc_core` itself.

## Test plan
- Drive op_1 with 0, 1, 2, 3 and 4, holding each for 0.1 ns. Expected response: resul_soma = 4, 5, 6, 7 and 8, with wrap = 0 each time.
- Drive op_1 = 0xFFFF_FFFC. Expected response: resul_soma = 0x0000_0000 and wrap = 1. Then drive 0xFFFF_FFFF. Expected response: resul_soma = 0x0000_0003 and wrap = 1.
- Hold rst_n = 0 and toggle clk with op_1 = 0x0040_0000. Expected response: resul_soma = 0x0040_0004 while resul_soma_q = 0 and wrap_q = 0.
- Release rst_n, set en = 1 and op_1 = 0x0040_0000, then clock once. Expected response: resul_soma_q = 0x0040_0004. Then set op_1 = 0x0040_0004 with en = 0 and clock. Expected response: resul_soma_q stays at 0x0040_0004.
- With en = 1 and resul_soma_q = 0x0040_0008, assert rst_n mid-cycle, away from a clock edge. Expected response: resul_soma_q = 0 with no clock edge needed.
- Run 1000 random op_1 values. Expected response: resul_soma == op_1 + 4 mod 2**32 and wrap == (op_1 >= 0xFFFF_FFFC).
